// File: rtl/result_digit_emitter.sv
// result_digit_emitter
//
// Converts a 32-bit unsigned result into 10-digit BCD with a sequential
// shift-add-3 (double dabble), one iteration per clock. It then replays
// the significant decimal digits, most significant first, as keypad-style
// strobes so that any keypad-fed consumer can be loaded as if the value
// had been typed.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   start       conversion request, sampled only in IDLE
//   resultado   32-bit unsigned operand, captured on the accepting edge
//   digit       current BCD digit; valid while newDigit=1, held through the gap
//   newDigit    digit strobe: HOLD_CYCLES high, then GAP_CYCLES low per digit
//   bcd         full 10-digit BCD of the captured operand (published in LOAD)
//   digitCount  number of significant digits, 1..10 (published in LOAD)
//   busy        high from the accepting edge through the done pulse
//   done        single-cycle pulse after the last digit's gap
//   state_dbg   current FSM state encoding, for observation only
//
// Handshake: start is a level request with no ready/ack. It is honoured
// only on an edge where the FSM is in IDLE; requests at any other time are
// dropped, not queued. newDigit is a strobe with no back-pressure, and the
// consumer is expected to act on its rising edge.

module result_digit_emitter #(
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] resultado,
   output logic [3:0]  digit,
   output logic        newDigit,
   output logic [39:0] bcd,
   output logic [3:0]  digitCount,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_LOAD    = 3'd2,
      S_DRIVE   = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

   state_t      state;
   // Working register: upper 40 bits are the BCD accumulator, lower 32 the
   // binary operand being shifted out.
   logic [71:0] work;
   logic [4:0]  iter;
   logic [3:0]  ptr;
   logic [15:0] cnt;

   logic [3:0]  load_count;
   logic [3:0]  load_msd;

   // One double-dabble iteration: every BCD nibble >= 5 gets +3, then the
   // whole {bcd,bin} register shifts left by one.
   function automatic logic [71:0] dabble_step(input logic [71:0] w);
      logic [71:0] t;
      t = w;
      for (int i = 0; i < 10; i++) begin
         if (t[32 + 4*i +: 4] >= 4'd5)
            t[32 + 4*i +: 4] = t[32 + 4*i +: 4] + 4'd3;
      end
      return {t[70:0], 1'b0};
   endfunction

   // Index of the highest nonzero nibble plus one; a zero value still has
   // one significant digit.
   function automatic logic [3:0] sig_digits(input logic [39:0] b);
      logic [3:0] n;
      n = 4'd1;
      for (int i = 0; i < 10; i++) begin
         if (b[4*i +: 4] != 4'd0)
            n = 4'(i + 1);
      end
      return n;
   endfunction

   function automatic logic [3:0] nibble_at(input logic [39:0] b,
                                            input logic [3:0]  p);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (p == 4'(i))
            r = b[4*i +: 4];
      end
      return r;
   endfunction

   // LOAD reads the finished accumulator straight from the working register
   // so the first digit can be presented on the same edge that publishes bcd.
   assign load_count = sig_digits(work[71:32]);
   assign load_msd   = nibble_at(work[71:32], load_count - 4'd1);
   assign state_dbg  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         work       <= '0;
         iter       <= '0;
         ptr        <= '0;
         cnt        <= '0;
         digit      <= '0;
         newDigit   <= 1'b0;
         bcd        <= '0;
         digitCount <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  work  <= {40'd0, resultado};
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= S_CONVERT;
               end
            end

            S_CONVERT: begin
               work <= dabble_step(work);
               iter <= iter + 5'd1;
               if (iter == 5'd31)
                  state <= S_LOAD;
            end

            S_LOAD: begin
               bcd        <= work[71:32];
               digitCount <= load_count;
               ptr        <= load_count - 4'd1;
               digit      <= load_msd;
               newDigit   <= 1'b1;
               cnt        <= '0;
               state      <= S_DRIVE;
            end

            S_DRIVE: begin
               if (cnt == HOLD_LAST) begin
                  newDigit <= 1'b0;
                  cnt      <= '0;
                  state    <= S_GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (ptr != 4'd0) begin
                     ptr      <= ptr - 4'd1;
                     digit    <= nibble_at(bcd, ptr - 4'd1);
                     newDigit <= 1'b1;
                     state    <= S_DRIVE;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state    <= S_IDLE;
               newDigit <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_digit_emitter.sv
// Bench for result_digit_emitter: expected digits are derived by decimal
// division of the operand and queued when a conversion is started; each
// newDigit rising edge pops and compares one entry.

module tb_result_digit_emitter;

   localparam int HOLD = 2;
   localparam int GAP  = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] resultado;
   logic [3:0]  digit;
   logic        newDigit;
   logic [39:0] bcd;
   logic [3:0]  digitCount;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [3:0]  exp_q[$];
   logic [31:0] next_val;

   result_digit_emitter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .resultado  (resultado),
      .digit      (digit),
      .newDigit   (newDigit),
      .bcd        (bcd),
      .digitCount (digitCount),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_digit"},      digit,      0);
      chk({tag, "_newDigit"},   newDigit,   0);
      chk({tag, "_bcd"},        bcd,        0);
      chk({tag, "_digitCount"}, digitCount, 0);
      chk({tag, "_busy"},       busy,       0);
      chk({tag, "_done"},       done,       0);
      chk({tag, "_state"},      state_dbg,  0);
   endtask

   // driver: present start for one edge (or keep it high)
   task automatic start_conv(input logic [31:0] v, input bit keep);
      @(negedge clk);
      start     = 1'b1;
      resultado = v;
      @(posedge clk);
      #1;
      if (!keep) start = 1'b0;
      chk("busy_accept", busy, 1);
   endtask

   // monitor + scoreboard; first negedge seen is cycle 1 after the accept edge
   task automatic watch(input logic [31:0] v, input bit noise, input bit keep);
      logic [3:0]  ds[10];
      logic [31:0] tmp;
      logic [39:0] ebcd;
      int          n, first_k, hi_run, lo_run, rises;
      bit          prev, seen_done;
      tmp = v;
      n = 0;
      do begin
         ds[n] = 4'(tmp % 10);
         tmp   = tmp / 10;
         n++;
      end while (tmp != 0);
      ebcd = '0;
      for (int i = 0; i < n; i++) ebcd[4*i +: 4] = ds[i];
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(ds[i]);

      prev = 1'b0; first_k = -1; hi_run = 0; lo_run = 0; rises = 0;
      seen_done = 1'b0;
      for (int k = 1; k <= 400 && !seen_done; k++) begin
         @(negedge clk);
         if (newDigit && !prev) begin
            rises++;
            if (first_k < 0) first_k = k;
            else chk("gap_len", lo_run, GAP);
            if (exp_q.size() == 0) chk("extra_digit", 1, 0);
            else chk("digit", digit, exp_q.pop_front());
            hi_run = 0;
         end
         if (!newDigit && prev) begin
            chk("hold_len", hi_run, HOLD);
            lo_run = 0;
         end
         if (newDigit) hi_run++;
         else lo_run++;
         if (done) begin
            seen_done = 1'b1;
            chk("done_cycle", k, 33 + n * (HOLD + GAP) + 1);
            chk("first_rise", first_k, 34);
            chk("bcd", bcd, ebcd);
            chk("digitCount", digitCount, n);
            chk("pulse_count", rises, n);
            chk("queue_empty", exp_q.size(), 0);
            chk("busy_at_done", busy, 1);
            if (keep) resultado = next_val;
            else start = 1'b0;
         end else if (noise) begin
            start     = 1'($urandom_range(0, 1));
            resultado = $urandom;
         end
         prev = newDigit;
      end
      if (!seen_done) chk("done_timeout", 0, 1);
      exp_q.delete();
   endtask

   task automatic do_run(input logic [31:0] v, input bit noise);
      start_conv(v, 1'b0);
      watch(v, noise, 1'b0);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("busy_off", busy, 0);
   endtask

   task automatic reset_mid(input logic [31:0] v, input int cycles,
                            input string tag);
      start_conv(v, 1'b0);
      repeat (cycles) @(negedge clk);
      reset = 1'b1;
      #1;
      chk_idle_outputs(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      resultado = '0;
      next_val  = '0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      reset = 1'b0;

      do_run(32'd0, 1'b0);
      do_run(32'd1234, 1'b0);
      do_run(32'd4294967295, 1'b0);
      do_run(32'd1000000, 1'b0);
      do_run(32'd987654321, 1'b1);
      for (int i = 0; i < 3; i++) do_run($urandom, 1'b0);

      // start held high across done: second conversion on the first IDLE edge
      next_val = 32'd90210;
      start_conv(32'd7, 1'b1);
      watch(32'd7, 1'b0, 1'b1);
      @(negedge clk);
      chk("b2b_busy_gap", busy, 0);
      chk("b2b_idle", state_dbg, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy_accept", busy, 1);
      watch(32'd90210, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_busy_off", busy, 0);

      reset_mid(32'd55555, 10, "rst_convert");
      reset_mid(32'd4321, 35, "rst_drive");
      do_run(32'd305, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
